// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - write-port bundle between the writeback sources and the arbiter
interface regfile_wr_arbiter_if #(
  parameter int W    = 16,
  parameter int NREG = 4,
  parameter int AW   = 2
);
  logic [2:0]      req;
  logic [2:0]      lock;
  logic [AW-1:0]   addr0;
  logic [AW-1:0]   addr1;
  logic [AW-1:0]   addr2;
  logic [W-1:0]    data0;
  logic [W-1:0]    data1;
  logic [W-1:0]    data2;
  logic [2:0]      gnt;
  logic [NREG-1:0] reg_en;
  logic [W-1:0]    wr_data;
  logic            busy;
  logic            lock_err;

  modport master (
    output req, lock, addr0, addr1, addr2, data0, data1, data2,
    input  gnt, reg_en, wr_data, busy, lock_err
  );

  modport slave (
    input  req, lock, addr0, addr1, addr2, data0, data1, data2,
    output gnt, reg_en, wr_data, busy, lock_err
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin write-port arbiter with locked bursts and watchdog
module regfile_wr_arbiter #(
  parameter int W        = 16,
  parameter int NREG     = 4,
  parameter int AW       = 2,
  parameter int LOCK_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_b,
  regfile_wr_arbiter_if.slave bus
);
  localparam int LW = $clog2(LOCK_MAX + 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          lock_err_q, lock_err_d;

  logic          gnt_vld;
  logic [1:0]    gnt_src;
  logic [1:0]    cand0, cand1, cand2, pick;
  logic          pick_vld;
  logic [AW-1:0] sel_addr;
  logic [W-1:0]  sel_data;

  function automatic logic [1:0] nxt(input logic [1:0] s);
    return (s >= 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // Round-robin scan starting at rr_ptr
  always_comb begin
    cand0    = rr_ptr_q;
    cand1    = nxt(cand0);
    cand2    = nxt(cand1);
    pick     = cand0;
    pick_vld = 1'b1;
    if (bus.req[cand0])      pick = cand0;
    else if (bus.req[cand1]) pick = cand1;
    else if (bus.req[cand2]) pick = cand2;
    else                     pick_vld = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    lcnt_d     = lcnt_q;
    lock_err_d = lock_err_q;
    gnt_vld    = 1'b0;
    gnt_src    = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_vld  = 1'b1;
          gnt_src  = pick;
          rr_ptr_d = nxt(pick);
          if (bus.lock[pick]) begin
            state_d = S_LOCKED;
            owner_d = pick;
            lcnt_d  = LW'(1);
          end
        end
      end
      S_LOCKED: begin
        if (lcnt_q == LW'(LOCK_MAX)) begin
          lock_err_d = 1'b1;
          state_d    = S_IDLE;
          lcnt_d     = '0;
        end else if (bus.req[owner_q]) begin
          gnt_vld  = 1'b1;
          gnt_src  = owner_q;
          rr_ptr_d = nxt(owner_q);
          if (bus.lock[owner_q]) begin
            lcnt_d = lcnt_q + LW'(1);
          end else begin
            state_d = S_IDLE;
            lcnt_d  = '0;
          end
        end else begin
          state_d = S_IDLE;
          lcnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Nothing may reach the register cells while reset is held
    if (!rst_b) gnt_vld = 1'b0;
  end

  always_comb begin
    sel_addr = bus.addr0;
    sel_data = bus.data0;
    case (gnt_src)
      2'd1: begin
        sel_addr = bus.addr1;
        sel_data = bus.data1;
      end
      2'd2: begin
        sel_addr = bus.addr2;
        sel_data = bus.data2;
      end
      default: ;
    endcase
    bus.gnt     = '0;
    bus.reg_en  = '0;
    bus.wr_data = '0;
    if (gnt_vld) begin
      bus.gnt     = 3'b001 << gnt_src;
      bus.wr_data = sel_data;
      // Out-of-range index still completes the handshake, but writes nothing
      if (32'(sel_addr) < NREG) bus.reg_en = NREG'(1) << sel_addr;
    end
  end

  assign bus.busy     = rst_b && (state_q == S_LOCKED);
  assign bus.lock_err = lock_err_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      owner_q    <= 2'd0;
      rr_ptr_q   <= 2'd0;
      lcnt_q     <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      lcnt_q     <= lcnt_d;
      lock_err_q <= lock_err_d;
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed vector bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;
  logic clk;
  logic rst_b;
  int   checks;
  int   errors;

  regfile_wr_arbiter_if #(.W(16), .NREG(4), .AW(2)) bus ();

  regfile_wr_arbiter #(.W(16), .NREG(4), .AW(2), .LOCK_MAX(8)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_b;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [1:0]  a0;
    logic [15:0] d0;
    logic [1:0]  a1;
    logic [15:0] d1;
    logic [1:0]  a2;
    logic [15:0] d2;
    logic [2:0]  gnt;
    logic [3:0]  reg_en;
    logic [15:0] wr;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [2:0] req, logic [2:0] lock,
                              logic [1:0] a0, logic [15:0] d0,
                              logic [1:0] a1, logic [15:0] d1,
                              logic [1:0] a2, logic [15:0] d2,
                              logic [2:0] gnt, logic [3:0] reg_en,
                              logic [15:0] wr, logic busy);
    vec_t v;
    v.rst_b = r; v.req = req; v.lock = lock;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.a2 = a2; v.d2 = d2;
    v.gnt = gnt; v.reg_en = reg_en; v.wr = wr; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [2:0] req, input logic [2:0] lock);
    rst_b    = r;
    bus.req  = req;
    bus.lock = lock;
  endtask

  task automatic set_src(input logic [1:0] a0, input logic [15:0] d0,
                         input logic [1:0] a1, input logic [15:0] d1,
                         input logic [1:0] a2, input logic [15:0] d2);
    bus.addr0 = a0; bus.data0 = d0;
    bus.addr1 = a1; bus.data1 = d1;
    bus.addr2 = a2; bus.data2 = d2;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] gnt, input logic [3:0] reg_en,
                            input logic [15:0] wr, input logic busy, input logic err);
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(gnt));
    check({tag, ".reg_en"}, 32'(bus.reg_en), 32'(reg_en));
    check({tag, ".wr_data"}, 32'(bus.wr_data), 32'(wr));
    check({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    check({tag, ".lock_err"}, 32'(bus.lock_err), 32'(err));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 3'b000, 3'b000);
    set_src(2'd1, 16'h1111, 2'd2, 16'h2222, 2'd3, 16'h3333);

    tbl.push_back(mk(0, 3'b111, 3'b000, 1, 16'h1111, 2, 16'h2222, 3, 16'h3333, 3'b000, 4'b0000, 16'h0000, 0));
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(1, 3'b111, 3'b000, 1, 16'h1111, 2, 16'h2222, 3, 16'h3333, 3'b001, 4'b0010, 16'h1111, 0));
      tbl.push_back(mk(1, 3'b111, 3'b000, 1, 16'h1111, 2, 16'h2222, 3, 16'h3333, 3'b010, 4'b0100, 16'h2222, 0));
      tbl.push_back(mk(1, 3'b111, 3'b000, 1, 16'h1111, 2, 16'h2222, 3, 16'h3333, 3'b100, 4'b1000, 16'h3333, 0));
    end
    tbl.push_back(mk(1, 3'b010, 3'b000, 1, 16'h1111, 2, 16'hBEEF, 3, 16'h3333, 3'b010, 4'b0100, 16'hBEEF, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 1, 16'h1111, 2, 16'h2222, 3, 16'h3333, 3'b100, 4'b1000, 16'h3333, 0));
    tbl.push_back(mk(1, 3'b011, 3'b001, 1, 16'h1111, 2, 16'h2222, 3, 16'h3333, 3'b001, 4'b0010, 16'h1111, 0));
    tbl.push_back(mk(1, 3'b011, 3'b000, 1, 16'h1111, 2, 16'h2222, 3, 16'h3333, 3'b001, 4'b0010, 16'h1111, 1));
    tbl.push_back(mk(1, 3'b010, 3'b000, 1, 16'h1111, 2, 16'h2222, 3, 16'h3333, 3'b010, 4'b0100, 16'h2222, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 16'h1111, 2, 16'h2222, 3, 16'h3333, 3'b000, 4'b0000, 16'h0000, 0));
    tbl.push_back(mk(1, 3'b101, 3'b000, 1, 16'h1111, 2, 16'h2222, 0, 16'h0F0F, 3'b100, 4'b0001, 16'h0F0F, 0));
    tbl.push_back(mk(1, 3'b110, 3'b000, 1, 16'h1111, 2, 16'h2222, 3, 16'h3333, 3'b010, 4'b0100, 16'h2222, 0));
    tbl.push_back(mk(1, 3'b001, 3'b000, 0, 16'hA5A5, 2, 16'h2222, 3, 16'h3333, 3'b001, 4'b0001, 16'hA5A5, 0));
    tbl.push_back(mk(1, 3'b100, 3'b011, 1, 16'h1111, 2, 16'h2222, 3, 16'h3333, 3'b100, 4'b1000, 16'h3333, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 16'h1111, 2, 16'h2222, 3, 16'h3333, 3'b000, 4'b0000, 16'h0000, 0));

    tick();
    foreach (tbl[i]) begin
      drive(tbl[i].rst_b, tbl[i].req, tbl[i].lock);
      set_src(tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1, tbl[i].a2, tbl[i].d2);
      #4;
      expect_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].reg_en, tbl[i].wr, tbl[i].busy, 1'b0);
      tick();
    end

    set_src(2'd1, 16'h1111, 2'd2, 16'h2222, 2'd3, 16'h3333);
    drive(1'b1, 3'b010, 3'b010);
    #4; expect_out("drop0", 3'b010, 4'b0100, 16'h2222, 1'b0, 1'b0); tick();
    drive(1'b1, 3'b101, 3'b000);
    #4; expect_out("drop1", 3'b000, 4'b0000, 16'h0000, 1'b1, 1'b0); tick();
    #4; expect_out("drop2", 3'b100, 4'b1000, 16'h3333, 1'b0, 1'b0); tick();

    for (int k = 0; k < 12; k++) begin
      logic [2:0]  eg;
      logic [3:0]  er;
      logic [15:0] ew;
      logic        eb;
      drive(1'b1, (k == 0) ? 3'b100 : 3'b101, 3'b100);
      if (k < 8 || k >= 10) begin
        eg = 3'b100; er = 4'b1000; ew = 16'h3333;
      end else if (k == 8) begin
        eg = 3'b000; er = 4'b0000; ew = 16'h0000;
      end else begin
        eg = 3'b001; er = 4'b0010; ew = 16'h1111;
      end
      eb = ((k >= 1) && (k <= 8)) || (k == 11);
      #4; expect_out($sformatf("wdog%0d", k), eg, er, ew, eb, k >= 9); tick();
    end

    drive(1'b0, 3'b111, 3'b111);
    for (int k = 0; k < 2; k++) begin
      #4;
      check($sformatf("rst%0d.gnt", k), 32'(bus.gnt), 32'd0);
      check($sformatf("rst%0d.reg_en", k), 32'(bus.reg_en), 32'd0);
      check($sformatf("rst%0d.wr_data", k), 32'(bus.wr_data), 32'd0);
      check($sformatf("rst%0d.busy", k), 32'(bus.busy), 32'd0);
      if (k == 1) check("rst1.lock_err", 32'(bus.lock_err), 32'd0);
      tick();
    end
    drive(1'b1, 3'b111, 3'b000);
    #4; expect_out("post_rst", 3'b001, 4'b0010, 16'h1111, 1'b0, 1'b0); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
